// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encoding, the FSM state type and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter width able to hold width-1; never narrower than one bit.
    function automatic int unsigned muldiv_iter_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned MULDIV_ITER_W = muldiv_iter_w(32);

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negation of a WIDTH-bit value.
// Ports: din (value), dout (-din modulo 2^WIDTH).
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = ~din + WIDTH'(1);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign fix-up cycle.
// Ports: clk, rst_n (async active-low); start/op/A/B request an operation;
//        flush aborts an in-flight op; wr_hi/wr_lo/wr_data implement MTHI/MTLO;
//        busy/done handshake; Hi/Lo register outputs; div_by_zero valid with done.
// Config: define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored.
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = muldiv_iter_w(WIDTH);
    localparam int unsigned AW    = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AW-1:0]    acc, acc_n;
    logic [WIDTH-1:0] opnd, opnd_n;
    logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
    logic             is_div, is_div_n;
    logic             dz, dz_n;
    logic             busy_n, done_n, dbz_n;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH:0]   add_hi, neg_opnd, div_hi, trial;
    logic [AW-1:0]    mul_step, div_step;

    // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign add_hi   = acc[AW-1:WIDTH] + {1'b0, opnd};
    assign mul_step = acc[0] ? {1'b0, add_hi, acc[WIDTH-1:1]} : {1'b0, acc[AW-1:1]};

    // Divide step: the shifted remainder is taken straight from the bits below the top; subtract by adding -divisor.
    twos_negate #(.WIDTH(WIDTH + 1)) u_neg_opnd (.din({1'b0, opnd}), .dout(neg_opnd));
    assign div_hi   = acc[2*WIDTH-1:WIDTH-1];
    assign trial    = div_hi + neg_opnd;
    assign div_step = (div_hi >= {1'b0, opnd}) ? {trial, acc[WIDTH-2:0], 1'b1}
                                               : {acc[AW-2:0], 1'b0};

`ifdef MULDIV_SIGNED_EN
    logic             sign_a, sign_a_n, sign_b, sign_b_n;
    logic [WIDTH-1:0] neg_a, neg_b, rem_neg;
    logic [2*WIDTH-1:0] prod_neg;

    twos_negate #(.WIDTH(WIDTH))     u_neg_a    (.din(A), .dout(neg_a));
    twos_negate #(.WIDTH(WIDTH))     u_neg_b    (.din(B), .dout(neg_b));
    twos_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (.din(acc[2*WIDTH-1:0]), .dout(prod_neg));
    twos_negate #(.WIDTH(WIDTH))     u_neg_rem  (.din(acc[2*WIDTH-1:WIDTH]), .dout(rem_neg));

    assign mag_a = (op[0] && A[WIDTH-1]) ? neg_a : A;
    assign mag_b = (op[0] && B[WIDTH-1]) ? neg_b : B;
`else
    logic op_sign_unused;

    assign op_sign_unused = op[0];
    assign mag_a = A;
    assign mag_b = B;
`endif

    // Fix-up: sign correction; divide-by-zero forces an all-ones quotient.
    // The low half of the 2W-bit negation equals the W-bit negation of the quotient.
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (sign_a ^ sign_b) res_lo = prod_neg[WIDTH-1:0];
            if (sign_a)          res_hi = rem_neg;
        end else if (sign_a ^ sign_b) begin
            res_hi = prod_neg[2*WIDTH-1:WIDTH];
            res_lo = prod_neg[WIDTH-1:0];
        end
`endif
        if (dz) res_lo = '1;
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        opnd_n   = opnd;
        is_div_n = is_div;
        dz_n     = dz;
        hi_n     = hi;
        lo_n     = lo;
`ifdef MULDIV_SIGNED_EN
        sign_a_n = sign_a;
        sign_b_n = sign_b;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !flush) begin
                    state_n  = ST_RUN;
                    cnt_n    = CNT_LAST;
                    is_div_n = op[1];
                    dz_n     = op[1] && (B == '0);
                    if (op[1]) begin
                        acc_n  = {(WIDTH + 1)'(0), mag_a};
                        opnd_n = mag_b;
                    end else begin
                        acc_n  = {(WIDTH + 1)'(0), mag_b};
                        opnd_n = mag_a;
                    end
`ifdef MULDIV_SIGNED_EN
                    sign_a_n = op[0] && A[WIDTH-1];
                    sign_b_n = op[0] && B[WIDTH-1];
`endif
                end else begin
                    state_n = ST_IDLE;
                    if (wr_hi) hi_n = wr_data;
                    if (wr_lo) lo_n = wr_data;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    acc_n = is_div ? div_step : mul_step;
                    if (cnt == '0) state_n = ST_FIX;
                    else           cnt_n   = cnt - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    hi_n    = res_hi;
                    lo_n    = res_lo;
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n == ST_RUN) || (state_n == ST_FIX);
        done_n = (state_n == ST_DONE);
        dbz_n  = done_n && dz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            opnd        <= opnd_n;
            is_div      <= is_div_n;
            dz          <= dz_n;
            hi          <= hi_n;
            lo          <= lo_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
`ifdef MULDIV_SIGNED_EN
            sign_a      <= sign_a_n;
            sign_b      <= sign_b_n;
`endif
        end
    end

    assign Hi = hi;
    assign Lo = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corner cases plus random ops
// compared against an arithmetic reference model. Honours MULDIV_SIGNED_EN like the design.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .Hi(Hi), .Lo(Lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        bit          s;
        longint      sp;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        s = o[0];
`else
        s = 1'b0;
`endif
        ed = 1'b0;
        if (!o[1]) begin
            if (s) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = 64'(sp);
            end else begin
                up = {32'd0, a} * {32'd0, b};
            end
            eh = up[63:32];
            el = up[31:0];
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
            ed = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                el = 32'h8000_0000;
                eh = 32'd0;
            end else begin
                el = 32'($signed(a) / $signed(b));
                eh = 32'($signed(a) % $signed(b));
            end
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Starts an op at the current negedge and returns at the negedge where done is seen.
    // poke_at>0 pulses start/wr_hi/wr_lo during that busy cycle; wr_same writes on the accept edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input bit wr_same);
        logic [31:0] eh, el, h0, l0;
        logic        ed;
        int          n;
        bit          busy_ok, stable;
        string       id;
        model(o, a, b, eh, el, ed);
        id = $sformatf("op%0d a=%h b=%h", o, a, b);
        h0 = Hi; l0 = Lo; busy_ok = 1'b1; stable = 1'b1;
        start = 1'b1; op = o; A = a; B = b;
        if (wr_same) begin
            wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == poke_at + 1) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            @(negedge clk);
            if (done) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (Hi !== h0 || Lo !== l0) stable = 1'b0;
            if (n == poke_at) begin
                start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = $urandom;
            end
        end while (n < 40);
        chk({"done_seen ", id}, 32'(done), 32'd1);
        chk({"latency ", id}, 32'(n), 32'(WIDTH + 1));
        chk({"busy_run ", id}, 32'(busy_ok), 32'd1);
        chk({"hilo_stable ", id}, 32'(stable), 32'd1);
        chk({"hi ", id}, Hi, eh);
        chk({"lo ", id}, Lo, el);
        chk({"div_by_zero ", id}, 32'(div_by_zero), 32'(ed));
        chk({"busy_at_done ", id}, 32'(busy), 32'd0);
    endtask

    // One cycle after DONE with no start: done/div_by_zero drop, unit idle.
    task automatic idle_check();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("dbz_one_cycle", 32'(div_by_zero), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wr_task(input bit h, input bit l, input logic [31:0] d);
        logic [31:0] eh, el;
        eh = h ? d : Hi;
        el = l ? d : Lo;
        wr_hi = h; wr_lo = l; wr_data = d;
        @(posedge clk);
        #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        @(negedge clk);
        chk("wr_hi_value", Hi, eh);
        chk("wr_lo_value", Lo, el);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          no_done;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        #1;
        chk("reset_hi", Hi, 32'd0);
        chk("reset_lo", Lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        chk("multu_max_hi", Hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", Lo, 32'h0000_0001);
        idle_check();

        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
        chk("mult_neg3x7_hi", Hi, 32'hFFFF_FFFF);
`else
        chk("mult_neg3x7_hi", Hi, 32'h0000_0006);
`endif
        chk("mult_neg3x7_lo", Lo, 32'hFFFF_FFEB);
        idle_check();

        do_op(2'b10, 32'd100, 32'd7, 0, 1'b0);
        chk("divu_100_7_lo", Lo, 32'd14);
        chk("divu_100_7_hi", Hi, 32'd2);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        idle_check();

        do_op(2'b10, 32'd5, 32'd0, 0, 1'b0);
        chk("divu_5_0_lo", Lo, 32'hFFFF_FFFF);
        chk("divu_5_0_hi", Hi, 32'd5);
        idle_check();
        do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
        idle_check();

        // Preload HI, then flush a MULTU in its tenth RUN cycle.
        wr_task(1'b1, 1'b0, 32'h0000_1234);
        start = 1'b1; op = 2'b00; A = $urandom; B = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_hi_kept", Hi, 32'h0000_1234);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        chk("flush_no_done", 32'(no_done), 32'd1);

        // start together with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1; op = 2'b10; A = 32'd9; B = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("start_with_flush_busy", 32'(busy), 32'd0);

        // Writes and a stray start while busy are ignored; write on the accept edge is dropped.
        do_op(2'b00, $urandom, $urandom, 12, 1'b0);
        idle_check();
        do_op(2'b10, $urandom, 32'($urandom) | 32'd1, 0, 1'b1);
        idle_check();
        wr_task(1'b1, 1'b1, 32'hA5A5_5A5A);

        // Asynchronous reset in the middle of RUN.
        start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hi", Hi, 32'd0);
        chk("midrst_lo", Lo, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);

        // Random ops, mostly back-to-back.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i % 6 == 0) ra = 32'h8000_0000;
            if (i % 3 == 0) idle_check();
            do_op(ro, ra, rb, (i % 5 == 0) ? $urandom_range(1, 30) : 0, (i % 7 == 0));
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
